// File: rtl/vec_mem_sequencer.sv
// Splits one LANES-wide vector load/store into BEATS narrow req/gnt/rvalid memory beats.
// Latency: store BEATS+1 cycles to done, load 2*BEATS+1 with immediate gnt/rvalid; stalls the pipeline until done.
// Backpressure: each request is held stable until mem_gnt; read beats wait in WAIT_R for mem_rvalid.
module vec_mem_sequencer #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 16,
    parameter int BEAT_LANES = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rmem,
    input  logic                         wmem,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [LANES*DATA_W-1:0]      wr_vec,
    output logic                         stall,
    output logic                         done,
    output logic [LANES*DATA_W-1:0]      rd_vec,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [BEAT_LANES*DATA_W-1:0] mem_wdata,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [BEAT_LANES*DATA_W-1:0] mem_rdata
);

    localparam int BEATS      = LANES / BEAT_LANES;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_DW    = BEAT_LANES * DATA_W;
    localparam int BEAT_BYTES = BEAT_DW / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [BEAT_W-1:0]         r_beat;
    logic [ADDR_W-1:0]         r_base;
    logic [LANES*DATA_W-1:0]   r_wvec;
    logic [LANES*DATA_W-1:0]   r_rd_vec;
    logic                      r_we;
    logic                      w_start;
    logic                      w_last;

    assign w_start = (r_state == S_IDLE) && (rmem || wmem);
    assign w_last  = (r_beat == BEAT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rmem || wmem) w_next = S_REQ;
            end
            S_REQ: begin
                if (mem_gnt) begin
                    if (!r_we)      w_next = S_WAIT_R;
                    else if (w_last) w_next = S_DONE;
                end
            end
            S_WAIT_R: begin
                if (mem_rvalid) w_next = w_last ? S_DONE : S_REQ;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, including the combinational IDLE stall.
    always_comb begin
        stall   = 1'b0;
        done    = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        if (rst) begin
            case (r_state)
                S_IDLE:   stall = rmem || wmem;
                S_REQ: begin
                    stall   = 1'b1;
                    mem_req = 1'b1;
                    mem_we  = r_we;
                end
                S_WAIT_R: stall = 1'b1;
                S_DONE:   done  = 1'b1;
                default:  stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat   <= '0;
            r_base   <= '0;
            r_wvec   <= '0;
            r_we     <= 1'b0;
            r_rd_vec <= '0;
        end else begin
            if (w_start) begin
                r_base <= base_addr;
                r_wvec <= wr_vec;
                r_we   <= wmem;
                r_beat <= '0;
            end else if (r_state == S_REQ && mem_gnt && r_we && !w_last) begin
                r_beat <= r_beat + 1'b1;
            end else if (r_state == S_WAIT_R && mem_rvalid) begin
                r_rd_vec[r_beat*BEAT_DW +: BEAT_DW] <= mem_rdata;
                if (!w_last) r_beat <= r_beat + 1'b1;
            end
        end
    end

    // Beat address wraps modulo 2^ADDR_W by construction of the adder width.
    assign mem_addr  = r_base + (ADDR_W'(r_beat) * ADDR_W'(BEAT_BYTES));
    assign mem_wdata = r_wvec[r_beat*BEAT_DW +: BEAT_DW];
    assign rd_vec    = r_rd_vec;

endmodule
